fpga_spi_cmd_master: RTL and testbench



---
 rtl/fpga_spi_cmd_master.sv | 171 +++++++++++++++++
 tb/tb_fpga_spi_cmd_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_spi_cmd_master.sv
// rtl/fpga_spi_cmd_master.sv - SPI initiator serialising 16-bit command words to the FPGA config receiver.
// Optional miso capture (rx_word/rx_valid) is enabled by defining FPGA_SPI_MISO_CAPTURE_EN.
module fpga_spi_cmd_master #(
  parameter int DIV    = 4,
  parameter int WORD_W = 16
) (
  input  logic              ck_1356meg,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [WORD_W-1:0] cmd_word,
  output logic              cmd_ready,
  output logic              busy,
  output logic              spck,
  output logic              mosi,
  output logic              ncs,
`ifdef FPGA_SPI_MISO_CAPTURE_EN
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_valid,
`endif
  input  logic              miso
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  localparam logic [7:0] PH_LAST  = 8'(DIV - 1);
  localparam logic [4:0] BITS_ALL = 5'(WORD_W);

  state_t            state, state_n;
  logic [7:0]        phase, phase_n;
  logic [4:0]        bit_cnt, bit_n;
  logic [WORD_W-1:0] shreg, shreg_n;
  logic              ncs_n, spck_n, mosi_n, ready_n, busy_n;

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ncs       <= 1'b1;
      spck      <= 1'b0;
      mosi      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      bit_cnt   <= bit_n;
      shreg     <= shreg_n;
      ncs       <= ncs_n;
      spck      <= spck_n;
      mosi      <= mosi_n;
      cmd_ready <= ready_n;
      busy      <= busy_n;
    end
  end

  // Outputs are computed as next-state values so every pin comes straight from a flop.
  always_comb begin
    state_n = state;
    phase_n = phase;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    ncs_n   = ncs;
    spck_n  = spck;
    mosi_n  = mosi;
    ready_n = cmd_ready;
    busy_n  = busy;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        busy_n  = 1'b0;
        ncs_n   = 1'b1;
        spck_n  = 1'b0;
        mosi_n  = 1'b0;
        if (cmd_valid && cmd_ready) begin
          shreg_n = cmd_word;
          mosi_n  = cmd_word[WORD_W-1];
          ncs_n   = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
          phase_n = '0;
          bit_n   = '0;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          spck_n  = 1'b1;
          bit_n   = bit_cnt + 5'd1;
          state_n = HIGH;
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      HIGH: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          spck_n  = 1'b0;
          shreg_n = {shreg[WORD_W-2:0], 1'b0};
          mosi_n  = shreg[WORD_W-2];
          state_n = LOW;
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      LOW: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          if (bit_cnt < BITS_ALL) begin
            spck_n  = 1'b1;
            bit_n   = bit_cnt + 5'd1;
            state_n = HIGH;
          end else begin
            // The low phase of the final bit already served as ncs hold time.
            ncs_n   = 1'b1;
            mosi_n  = 1'b0;
            state_n = GAP;
          end
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      GAP: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          ready_n = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          phase_n = phase + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

`ifdef FPGA_SPI_MISO_CAPTURE_EN
  logic [WORD_W-1:0] rx_shift;
  logic              spck_rise;
  logic              ncs_rise;

  assign spck_rise = spck_n & ~spck;
  // Only a completed frame raises ncs through the FSM; reset forces it without a pulse.
  assign ncs_rise  = ncs_n & ~ncs;

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      rx_shift <= '0;
      rx_word  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (spck_rise) begin
        rx_shift <= {rx_shift[WORD_W-2:0], miso};
      end
      if (ncs_rise) begin
        rx_word  <= rx_shift;
        rx_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
`endif

endmodule

// File: tb/tb_fpga_spi_cmd_master.sv
// tb/tb_fpga_spi_cmd_master.sv - directed bench for fpga_spi_cmd_master at DIV=4 and DIV=1.
module tb_fpga_spi_cmd_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cv4 = 1'b0, cv1 = 1'b0;
  logic [15:0] cw4 = '0, cw1 = '0;
  logic miso4 = 1'b0, miso1 = 1'b0;
  logic ready4, busy4, spck4, mosi4, ncs4;
  logic ready1, busy1, spck1, mosi1, ncs1;
`ifdef FPGA_SPI_MISO_CAPTURE_EN
  logic [15:0] rx_word4, rx_word1;
  logic rx_valid4, rx_valid1;
`endif

  always #5 clk = ~clk;

  fpga_spi_cmd_master #(.DIV(4), .WORD_W(16)) u_dut4 (
    .ck_1356meg(clk), .rst(rst), .cmd_valid(cv4), .cmd_word(cw4),
    .cmd_ready(ready4), .busy(busy4), .spck(spck4), .mosi(mosi4), .ncs(ncs4),
`ifdef FPGA_SPI_MISO_CAPTURE_EN
    .rx_word(rx_word4), .rx_valid(rx_valid4),
`endif
    .miso(miso4)
  );

  fpga_spi_cmd_master #(.DIV(1), .WORD_W(16)) u_dut1 (
    .ck_1356meg(clk), .rst(rst), .cmd_valid(cv1), .cmd_word(cw1),
    .cmd_ready(ready1), .busy(busy1), .spck(spck1), .mosi(mosi1), .ncs(ncs1),
`ifdef FPGA_SPI_MISO_CAPTURE_EN
    .rx_word(rx_word1), .rx_valid(rx_valid1),
`endif
    .miso(miso1)
  );

  bit sel = 1'b0;
  logic m_spck, m_mosi, m_ncs, m_ready, m_busy;
  assign m_spck  = sel ? spck1  : spck4;
  assign m_mosi  = sel ? mosi1  : mosi4;
  assign m_ncs   = sel ? ncs1   : ncs4;
  assign m_ready = sel ? ready1 : ready4;
  assign m_busy  = sel ? busy1  : busy4;

  int compared = 0;
  int failed = 0;

  logic [15:0] mon_word;
  int mon_rises, mon_ncs_low, mon_ncs_rise, mon_ready, mon_first, mon_last, mon_viol, mon_hi_bad;
  logic c1_ncs, c1_ready, c1_busy, c1_mosi;
  int rxv_count, rxv_cyc;
  logic [15:0] miso_pat = '0;
  logic [7:0] conf_word = '0, divisor = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) cv1 = v; else cv4 = v;
  endtask

  // Waits for cmd_ready, offers w, and returns in cycle 1 of the frame.
  task automatic send(input logic [15:0] w, input bit hold);
    int n = 0;
    while (!m_ready && n < 500) begin
      step();
      n++;
    end
    check("ready_before_send", {31'd0, m_ready}, 32'd1);
    set_valid(1'b1);
    if (sel) cw1 = w; else cw4 = w;
    miso4 = miso_pat[15];
    step();
    if (!hold) set_valid(1'b0);
  endtask

  // Receiver model: shifts mosi on every spck rise, decodes the word once ncs rises.
  task automatic monitor(input int div, input bit disturb);
    int c = 1;
    int last_change = 1;
    int last_rise = -1000;
    logic prev_spck = 1'b0;
    logic prev_mosi;
    mon_word = '0; mon_rises = 0; mon_ncs_low = 0; mon_ncs_rise = 0; mon_ready = 0;
    mon_first = -1; mon_last = -1; mon_viol = 0; mon_hi_bad = 0; rxv_count = 0; rxv_cyc = -1;
    c1_ncs = m_ncs; c1_ready = m_ready; c1_busy = m_busy; c1_mosi = m_mosi;
    prev_mosi = m_mosi;
    while (c <= 2000) begin
      if (m_spck && !prev_spck) begin
        mon_word = {mon_word[14:0], m_mosi};
        if (c - last_change < div) mon_viol++;
        if (mon_first < 0) mon_first = c;
        mon_last = c;
        last_rise = c;
        mon_rises++;
        if (mon_rises < 16) miso4 = miso_pat[15 - mon_rises];
      end
      if (c > 1 && m_mosi !== prev_mosi) begin
        if (c - last_rise < div) mon_viol++;
        last_change = c;
      end
      if (m_spck && m_ncs) mon_hi_bad++;
      if (!m_ncs) mon_ncs_low++;
      else if (mon_ncs_low > 0 && mon_ncs_rise == 0) mon_ncs_rise = c;
`ifdef FPGA_SPI_MISO_CAPTURE_EN
      if (!sel && rx_valid4) begin
        rxv_count++;
        rxv_cyc = c;
      end
`endif
      if (m_ready) begin
        mon_ready = c;
        break;
      end
      if (disturb) begin
        cv4 = (c < 100) && (c % 16 == 5);
        if (c % 16 == 5) cw4 = ~cw4;
      end
      prev_spck = m_spck;
      prev_mosi = m_mosi;
      step();
      c++;
    end
    if (mon_ncs_low > 0) begin
      if (mon_word[15:12] == 4'h1) conf_word = mon_word[7:0];
      if (mon_word[15:12] == 4'h2) divisor = mon_word[7:0];
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] w, input int div);
    check({tag, "_word"}, {16'd0, mon_word}, {16'd0, w});
    check({tag, "_rises"}, mon_rises, 16);
    check({tag, "_ncs_low"}, mon_ncs_low, 33 * div);
    check({tag, "_first_rise"}, mon_first, 1 + div);
    check({tag, "_last_rise"}, mon_last, 1 + 31 * div);
    check({tag, "_ncs_rise"}, mon_ncs_rise, 1 + 33 * div);
    check({tag, "_ready_cyc"}, mon_ready, 1 + 34 * div);
    check({tag, "_mosi_stable"}, mon_viol, 0);
    check({tag, "_spck_ncs_high"}, mon_hi_bad, 0);
    check({tag, "_c1"}, {28'd0, c1_ncs, c1_ready, c1_busy, c1_mosi}, {28'd0, 1'b0, 1'b0, 1'b1, w[15]});
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    step();
    step();
    check("rst_outputs4", {27'd0, ncs4, spck4, mosi4, ready4, busy4}, {27'd0, 5'b10000});
    check("rst_outputs1", {27'd0, ncs1, spck1, mosi1, ready1, busy1}, {27'd0, 5'b10000});
    rst = 1'b0;
    step();
    check("ready_after_rst", {30'd0, ready4, busy4}, {30'd0, 2'b10});

    sel = 1'b0;
    send(16'h1005, 1'b0);
    monitor(4, 1'b0);
    check_frame("f1005", 16'h1005, 4);
    check("conf_1005", {24'd0, conf_word}, 32'h05);

    send(16'h20A7, 1'b1);
    monitor(4, 1'b0);
    check_frame("f20a7", 16'h20A7, 4);
    check("divisor_a7", {24'd0, divisor}, 32'hA7);
    check("gap_ncs_high", mon_ready + 1 - mon_ncs_rise, 5);
    cw4 = 16'h1003;
    step();
    cv4 = 1'b0;
    monitor(4, 1'b0);
    check_frame("f1003", 16'h1003, 4);
    check("conf_03", {24'd0, conf_word}, 32'h03);

    send(16'h10C3, 1'b0);
    monitor(4, 1'b1);
    cv4 = 1'b0;
    check_frame("fdisturb", 16'h10C3, 4);
    step();
    step();
    check("no_extra_accept", {30'd0, ncs4, ready4}, {30'd0, 2'b11});

    sel = 1'b1;
    send(16'hFFFF, 1'b0);
    monitor(1, 1'b0);
    check_frame("d1_ffff", 16'hFFFF, 1);
    send(16'h0000, 1'b0);
    monitor(1, 1'b0);
    check_frame("d1_0000", 16'h0000, 1);
    send(16'hA5A5, 1'b0);
    monitor(1, 1'b0);
    check_frame("d1_a5a5", 16'hA5A5, 1);

    sel = 1'b0;
    send(16'h20FF, 1'b0);
    for (int c = 1; c < 60; c++) step();
    check("mid_frame_ncs", {31'd0, ncs4}, 32'd0);
    rst = 1'b1;
    step();
    check("rst_mid_61", {28'd0, ncs4, spck4, ready4, busy4}, {28'd0, 4'b1000});
    rst = 1'b0;
    step();
    check("rst_mid_62", {31'd0, ready4}, 32'd1);
    send(16'h1001, 1'b0);
    monitor(4, 1'b0);
    check_frame("f1001", 16'h1001, 4);
    check("conf_01", {24'd0, conf_word}, 32'h01);

`ifdef FPGA_SPI_MISO_CAPTURE_EN
    miso_pat = 16'hBEEF;
    send(16'h1002, 1'b0);
    monitor(4, 1'b0);
    check_frame("fmiso", 16'h1002, 4);
    check("rx_word", {16'd0, rx_word4}, 32'hBEEF);
    check("rx_valid_count", rxv_count, 1);
    check("rx_valid_cycle", rxv_cyc, 1 + 33 * 4);
    miso_pat = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
